// File: rtl/sysahb_matrix_mux.sv
// ---------------------------------------------------------------------------
// sysahb_matrix_mux
//   System-AHB address decoder, integrated ERROR default slave and response
//   multiplexer for up to 8 slaves. It also has a stall-timeout watchdog and
//   capture of the first error address.
//
//   Ports
//     sys_clk, sys_reset      clock, synchronous active-high reset
//     sysahb_haddr/htrans     master address phase
//     sysahb_hsel             per-slave select, combinational, one-hot or zero
//     slv_hreadyout/hresp/    per-slave data-phase responses (hrdata flattened,
//     slv_hrdata              slave i at [32*i+31:32*i])
//     sysahb_hready/hresp/    multiplexed bus response; hready is also fed
//     sysahb_hrdata           back to the slaves
//     err_clr                 clears the error capture
//     err_valid/cause/addr    sticky first-error record (cause 1 = timeout)
// ---------------------------------------------------------------------------

// Single region comparator, one instance per slave.
module sysahb_region_match #(
  parameter logic [31:0] BASE = 32'h0,
  parameter logic [31:0] MASK = 32'h0
) (
  input  logic [31:0] haddr,
  output logic        hit
);
  assign hit = (haddr & MASK) == BASE;
endmodule

module sysahb_matrix_mux #(
  parameter int                         NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0]   ADDR_BASE  = (NUM_SLAVES*32)'(
    {32'hA000_0000, 32'h6000_0000, 32'h4000_0000, 32'h2000_0000}),
  parameter logic [NUM_SLAVES*32-1:0]   ADDR_MASK  = (NUM_SLAVES*32)'(
    {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFF80_0000}),
  parameter int                         TIMEOUT    = 256
) (
  input  logic                       sys_clk,
  input  logic                       sys_reset,
  input  logic [31:0]                sysahb_haddr,
  input  logic [1:0]                 sysahb_htrans,
  output logic [NUM_SLAVES-1:0]      sysahb_hsel,
  input  logic [NUM_SLAVES-1:0]      slv_hreadyout,
  input  logic [NUM_SLAVES-1:0]      slv_hresp,
  input  logic [NUM_SLAVES*32-1:0]   slv_hrdata,
  output logic                       sysahb_hready,
  output logic                       sysahb_hresp,
  output logic [31:0]                sysahb_hrdata,
  input  logic                       err_clr,
  output logic                       err_valid,
  output logic                       err_cause,
  output logic [31:0]                err_addr
);

  localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {DEF_IDLE, DEF_ERR1, DEF_ERR2} def_state_t;

  logic [NUM_SLAVES-1:0] hit_vec;
  logic                  any_hit;
  logic [IW-1:0]         hit_idx;

  logic                  dsel_vld;   // data phase belongs to a real slave
  logic [IW-1:0]         dsel_idx;
  logic [31:0]           daddr;
  def_state_t            def_state, def_nxt;

  logic [TW-1:0]         to_cnt;
  logic                  stall, to_evt, dec_evt;

  // htrans[0] (SEQ vs NONSEQ, IDLE vs BUSY) does not change decode behaviour.
  logic unused_htrans0;
  assign unused_htrans0 = sysahb_htrans[0];

  // ---- decode ------------------------------------------------------------
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
    sysahb_region_match #(
      .BASE(ADDR_BASE[32*g +: 32]),
      .MASK(ADDR_MASK[32*g +: 32])
    ) u_match (
      .haddr(sysahb_haddr),
      .hit  (hit_vec[g])
    );
  end

  assign any_hit = |hit_vec;
  // Lowest matching index wins: isolate the lowest set bit.
  assign sysahb_hsel = hit_vec & (~hit_vec + NUM_SLAVES'(1));

  always_comb begin
    hit_idx = '0;
    for (int i = NUM_SLAVES-1; i >= 0; i--)
      if (hit_vec[i]) hit_idx = IW'(i);
  end

  // ---- data-phase select -------------------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      dsel_vld <= 1'b0;
      dsel_idx <= '0;
      daddr    <= '0;
    end else if (sysahb_hready) begin
      dsel_vld <= sysahb_htrans[1] & any_hit;
      dsel_idx <= hit_idx;
      daddr    <= sysahb_haddr;
    end
  end

  // ---- default slave: two-cycle ERROR ------------------------------------
  always_ff @(posedge sys_clk) begin
    if (sys_reset) def_state <= DEF_IDLE;
    else           def_state <= def_nxt;
  end

  always_comb begin
    def_nxt = DEF_IDLE;
    case (def_state)
      DEF_ERR1: def_nxt = DEF_ERR2;
      default:  def_nxt = DEF_IDLE;
    endcase
    // An unmapped NONSEQ/SEQ accepted in the ERR2 cycle chains straight into
    // a fresh ERROR response.
    if (sysahb_hready && sysahb_htrans[1] && !any_hit) def_nxt = DEF_ERR1;
  end

  // ---- response mux ------------------------------------------------------
  always_comb begin
    sysahb_hready = 1'b1;
    sysahb_hresp  = 1'b0;
    sysahb_hrdata = '0;
    case (def_state)
      DEF_ERR1: begin
        sysahb_hready = 1'b0;
        sysahb_hresp  = 1'b1;
      end
      DEF_ERR2: sysahb_hresp = 1'b1;
      default: begin
        if (dsel_vld) begin
          for (int i = 0; i < NUM_SLAVES; i++) begin
            if (dsel_idx == IW'(i)) begin
              sysahb_hready = slv_hreadyout[i];
              sysahb_hresp  = slv_hresp[i];
              sysahb_hrdata = slv_hrdata[32*i +: 32];
            end
          end
        end
      end
    endcase
  end

  // ---- stall watchdog ----------------------------------------------------
  // Saturates at TIMEOUT-1, so the event fires once per stall; the transfer
  // itself is left running.
  assign stall  = dsel_vld & ~sysahb_hready;
  assign to_evt = stall && (to_cnt == TW'(TIMEOUT-2));

  always_ff @(posedge sys_clk) begin
    if (sys_reset || sysahb_hready)                to_cnt <= '0;
    else if (stall && to_cnt != TW'(TIMEOUT-1))    to_cnt <= to_cnt + TW'(1);
  end

  // ---- error capture -----------------------------------------------------
  // Decode errors are logged in the first ERROR cycle, when daddr holds the
  // offending address. A new error coinciding with err_clr is kept.
  assign dec_evt = (def_state == DEF_ERR1);

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      err_valid <= 1'b0;
      err_cause <= 1'b0;
      err_addr  <= '0;
    end else if ((dec_evt || to_evt) && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_cause <= to_evt;
      err_addr  <= daddr;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sysahb_matrix_mux.sv
// Bench for sysahb_matrix_mux: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the bus.
module tb_sysahb_matrix_mux;
  localparam int NS = 4;
  localparam int TO = 256;
  // slave2 overlaps slave0's region so priority is exercised.
  localparam logic [NS*32-1:0] P_BASE =
    {32'hA000_0000, 32'h2000_0000, 32'h4000_0000, 32'h2000_0000};
  localparam logic [NS*32-1:0] P_MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hF000_0000, 32'hFF80_0000};

  logic [31:0] r_base [NS] = '{32'h2000_0000, 32'h4000_0000, 32'h2000_0000, 32'hA000_0000};
  logic [31:0] r_mask [NS] = '{32'hFF80_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000};

  logic                  sys_clk, sys_reset;
  logic [31:0]           haddr;
  logic [1:0]            htrans;
  logic [NS-1:0]         hsel;
  logic [NS-1:0]         s_rdy, s_resp;
  logic [NS-1:0][31:0]   s_rdata;
  logic                  hready, hresp;
  logic [31:0]           hrdata;
  logic                  err_clr, err_valid, err_cause;
  logic [31:0]           err_addr;

  sysahb_matrix_mux #(
    .NUM_SLAVES(NS), .ADDR_BASE(P_BASE), .ADDR_MASK(P_MASK), .TIMEOUT(TO)
  ) dut (
    .sys_clk(sys_clk), .sys_reset(sys_reset),
    .sysahb_haddr(haddr), .sysahb_htrans(htrans), .sysahb_hsel(hsel),
    .slv_hreadyout(s_rdy), .slv_hresp(s_resp), .slv_hrdata(s_rdata),
    .sysahb_hready(hready), .sysahb_hresp(hresp), .sysahb_hrdata(hrdata),
    .err_clr(err_clr), .err_valid(err_valid), .err_cause(err_cause),
    .err_addr(err_addr)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk = 0;
  int n_err = 0;

  // Model: what the current data phase is (0 none/idle, 1 slave, 2 unmapped),
  // which ERROR cycle it is in, consecutive stall count and the error record.
  int          m_kind, m_idx, m_ph, m_stall;
  logic [31:0] m_addr;
  logic        e_v, e_c;
  logic [31:0] e_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & r_mask[i]) == r_base[i]) return i;
    return -1;
  endfunction

  task automatic m_reset();
    m_kind = 0; m_idx = 0; m_ph = 0; m_stall = 0; m_addr = '0;
    e_v = 1'b0; e_c = 1'b0; e_a = '0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t,
                       input logic [NS-1:0] rdy, input logic clr);
    haddr = a; htrans = t; s_rdy = rdy; err_clr = clr;
  endtask

  // Check this cycle's outputs against the model at the falling edge, then
  // advance the model by one clock.
  task automatic tick();
    logic        eh, er, dec_e, to_e;
    logic [31:0] ed;
    logic [NS-1:0] esel;
    int d;
    @(negedge sys_clk);
    d = dec(haddr);
    esel = (d >= 0) ? NS'(1 << d) : '0;
    case (m_kind)
      1:       begin eh = s_rdy[m_idx]; er = s_resp[m_idx]; ed = s_rdata[m_idx]; end
      2:       begin eh = (m_ph == 2);  er = 1'b1;          ed = '0; end
      default: begin eh = 1'b1;         er = 1'b0;          ed = '0; end
    endcase
    chk("hsel", hsel, esel);
    chk("hready", hready, eh);
    chk("hresp", hresp, er);
    chk("hrdata", hrdata, ed);
    chk("err_valid", err_valid, e_v);
    chk("err_cause", err_cause, e_c);
    chk("err_addr", err_addr, e_a);
    if (sys_reset) m_reset();
    else begin
      dec_e = (m_kind == 2 && m_ph == 1);
      to_e  = 1'b0;
      if (eh) m_stall = 0;
      else if (m_kind == 1 && m_stall < TO-1) begin
        m_stall++;
        to_e = (m_stall == TO-1);
      end
      if ((dec_e || to_e) && (!e_v || err_clr)) begin
        e_v = 1'b1; e_c = to_e; e_a = m_addr;
      end else if (err_clr) e_v = 1'b0;
      if (eh) begin
        m_addr = haddr;
        if (!htrans[1])   m_kind = 0;
        else if (d >= 0)  begin m_kind = 1; m_idx = d; end
        else              begin m_kind = 2; m_ph = 1; end
      end else if (m_kind == 2) m_ph = 2;
    end
    @(posedge sys_clk); #1;
  endtask

  function automatic logic [31:0] rnd_addr();
    case ($urandom_range(0, 5))
      0:       return 32'h2000_0000 | ($urandom & 32'h007F_FFFF);
      1:       return 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
      2:       return 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
      3:       return 32'hA000_0000 | ($urandom & 32'h0FFF_FFFF);
      4:       return 32'h9000_0000 | ($urandom & 32'h0FFF_FFFF);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    s_resp = '0;
    for (int i = 0; i < NS; i++) s_rdata[i] = 32'hA0A0_0000 + 32'(i);
    drive(32'h0, 2'b00, '1, 1'b0);
    sys_reset = 1'b1;
    m_reset();
    @(posedge sys_clk); #1;
    tick();                       // reset values under reset
    sys_reset = 1'b0;

    // 1: NONSEQ read to slave0
    s_rdata[0] = 32'hDEAD_BEEF;
    drive(32'h2000_0010, 2'b10, '1, 1'b0); #1;
    chk("t1_hsel", hsel, 4'b0001);
    tick();
    drive(32'h0, 2'b00, '1, 1'b0); #1;
    chk("t1_hrdata", hrdata, 32'hDEAD_BEEF);
    chk("t1_hready", hready, 1'b1);
    tick();

    // 2: unmapped NONSEQ -> two-cycle ERROR and capture; IDLE unmapped is OKAY
    drive(32'h9000_0000, 2'b10, '1, 1'b0); #1;
    chk("t2_hsel", hsel, 4'b0000);
    tick();
    drive(32'h0, 2'b00, '1, 1'b0); #1;
    chk("t2_err1_hready", hready, 1'b0);
    chk("t2_err1_hresp", hresp, 1'b1);
    tick();
    #1;
    chk("t2_err2_hready", hready, 1'b1);
    chk("t2_err2_hresp", hresp, 1'b1);
    chk("t2_err_valid", err_valid, 1'b1);
    chk("t2_err_cause", err_cause, 1'b0);
    chk("t2_err_addr", err_addr, 32'h9000_0000);
    tick();
    drive(32'h0, 2'b00, '1, 1'b1);
    tick();
    drive(32'h9000_0000, 2'b00, '1, 1'b0);
    tick();
    drive(32'h0, 2'b00, '1, 1'b0); #1;
    chk("t2_idle_hresp", hresp, 1'b0);
    chk("t2_idle_noerr", err_valid, 1'b0);
    tick();

    // 3: slave1 stalls 300 cycles; timeout after the 255th stall cycle
    drive(32'h4000_0000, 2'b10, '1, 1'b0);
    tick();
    for (int k = 1; k <= 300; k++) begin
      drive(32'h0, 2'b00, 4'b1101, 1'b0); #1;
      chk("t3_to_flag", err_valid, k >= TO);
      tick();
    end
    drive(32'h0, 2'b00, '1, 1'b0); #1;
    chk("t3_release", hready, 1'b1);
    chk("t3_cause", err_cause, 1'b1);
    chk("t3_addr", err_addr, 32'h4000_0000);
    tick();

    // 4: first error wins; error coinciding with err_clr is captured
    drive(32'h9000_0008, 2'b10, '1, 1'b0); tick();
    drive(32'h0, 2'b00, '1, 1'b0); tick(); tick(); #1;
    chk("t4_keep_addr", err_addr, 32'h4000_0000);
    tick();
    drive(32'h9000_0004, 2'b10, '1, 1'b0); tick();
    drive(32'h0, 2'b00, '1, 1'b1); tick();
    drive(32'h0, 2'b00, '1, 1'b0); #1;
    chk("t4_clr_valid", err_valid, 1'b1);
    chk("t4_clr_addr", err_addr, 32'h9000_0004);
    chk("t4_clr_cause", err_cause, 1'b0);
    tick(); tick();

    // 5: overlap priority; pipelined slave0 (2 waits) then slave1
    s_rdata[0] = 32'h1111_1111;
    s_rdata[1] = 32'h2222_2222;
    drive(32'h2000_0010, 2'b10, '1, 1'b0); #1;
    chk("t5_prio", hsel, 4'b0001);
    tick();
    drive(32'h4000_0020, 2'b10, 4'b1110, 1'b0); #1;
    chk("t5_wait", hready, 1'b0);
    tick(); tick();
    drive(32'h4000_0020, 2'b10, '1, 1'b0); #1;
    chk("t5_d0", hrdata, 32'h1111_1111);
    tick();
    drive(32'h2100_0000, 2'b00, '1, 1'b0); #1;
    chk("t5_d1", hrdata, 32'h2222_2222);
    chk("t5_slave2", hsel, 4'b0100);
    tick();

    // 6: reset during the first ERROR cycle
    drive(32'h9000_0000, 2'b10, '1, 1'b0); tick();
    drive(32'h0, 2'b00, '1, 1'b0);
    sys_reset = 1'b1; #1;
    chk("t6_in_err1", hready, 1'b0);
    tick();
    sys_reset = 1'b0; #1;
    chk("t6_hready", hready, 1'b1);
    chk("t6_hresp", hresp, 1'b0);
    chk("t6_err_valid", err_valid, 1'b0);
    tick();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NS; i++) begin
        s_rdata[i] = $urandom;
        s_resp[i]  = ($urandom_range(0, 7) == 0);
      end
      drive(rnd_addr(), 2'($urandom),
            {($urandom_range(0,3) != 0), ($urandom_range(0,3) != 0),
             ($urandom_range(0,3) != 0), ($urandom_range(0,3) != 0)},
            ($urandom_range(0, 19) == 0));
      sys_reset = ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
